// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU data-memory responder.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_t;

    localparam int WORD_BYTES = 4;

    // An access is rejected when it is misaligned, beyond the array, or
    // asks for neither or both of load and store.
    function automatic logic access_error(
        input logic [31:0] addr,
        input logic        rd,
        input logic        wr,
        input logic [29:0] depth
    );
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = (addr[31:2] >= depth);
        return misaligned | out_of_range | (rd == wr);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Synchronous single-port word RAM; read data is registered every edge.
module mem_word_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Write-on-enable, read-first registered port; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
        rdata <= mem_r[idx];
    end

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data memory with valid/ready request and response channels,
// configurable wait latency and error flagging for bad accesses.
module data_memory_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] ReadData,
    output logic        AddrError
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [29:0]      DEPTH_LIMIT = 30'(DEPTH_WORDS);

    mem_state_t       state_r;
    mem_state_t       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic             mem_read_r;
    logic             mem_write_r;
    logic             req_ready_r;
    logic             resp_valid_r;
    logic             read_ok_r;
    logic             addr_error_r;
    logic             req_ready_nxt_s;
    logic             resp_valid_nxt_s;
    logic             access_s;
    logic             err_s;
    logic             we_s;
    logic [31:0]      ram_rdata_s;

    // The error check only ever looks at the latched request.
    assign err_s    = access_error(addr_r, mem_read_r, mem_write_r, DEPTH_LIMIT);
    assign access_s = (state_r == MEM_WAIT) && (cnt_r == CNT_ZERO);
    // A reset on the access edge aborts the store before it commits.
    assign we_s     = access_s && mem_write_r && !mem_read_r && !err_s && !Rst;

    mem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk  (Clk),
        .we   (we_s),
        .idx  (addr_r[IDX_W+1:2]),
        .wdata(wdata_r),
        .rdata(ram_rdata_s)
    );

    // State register with synchronous reset to IDLE.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= MEM_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic for IDLE -> WAIT -> RESP -> IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            MEM_IDLE: begin
                if (ReqValid) begin
                    next_state_s = MEM_WAIT;
                end else begin
                    next_state_s = MEM_IDLE;
                end
            end
            MEM_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    next_state_s = MEM_RESP;
                end else begin
                    next_state_s = MEM_WAIT;
                end
            end
            MEM_RESP: begin
                if (RespReady) begin
                    next_state_s = MEM_IDLE;
                end else begin
                    next_state_s = MEM_RESP;
                end
            end
            default: next_state_s = MEM_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state being entered so they can be registered.
    always_comb begin
        req_ready_nxt_s  = 1'b0;
        resp_valid_nxt_s = 1'b0;
        case (next_state_s)
            MEM_IDLE: req_ready_nxt_s  = 1'b1;
            MEM_WAIT: req_ready_nxt_s  = 1'b0;
            MEM_RESP: resp_valid_nxt_s = 1'b1;
            default:  req_ready_nxt_s  = 1'b0;
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
        end else begin
            req_ready_r  <= req_ready_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
        end
    end

    // Request latch, wait counter and response status flags.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_r        <= CNT_ZERO;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            read_ok_r    <= 1'b0;
            addr_error_r <= 1'b0;
        end else begin
            case (state_r)
                MEM_IDLE: begin
                    if (ReqValid) begin
                        addr_r      <= Address;
                        wdata_r     <= WriteData;
                        mem_read_r  <= MemRead;
                        mem_write_r <= MemWrite;
                        cnt_r       <= CNT_LOAD;
                    end
                end
                MEM_WAIT: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        read_ok_r    <= mem_read_r && !mem_write_r && !err_s;
                        addr_error_r <= err_s;
                    end
                end
                MEM_RESP: begin
                    if (RespReady) begin
                        read_ok_r    <= 1'b0;
                        addr_error_r <= 1'b0;
                    end
                end
                default: begin
                    read_ok_r    <= 1'b0;
                    addr_error_r <= 1'b0;
                end
            endcase
        end
    end

    assign ReqReady  = req_ready_r;
    assign RespValid = resp_valid_r;
    // RAM data is captured on the access edge; stores and errors present zero.
    assign ReadData  = read_ok_r ? ram_rdata_s : 32'd0;
    assign AddrError = addr_error_r;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed, table-driven bench for data_memory_responder (WAIT_CYCLES=2 and 0 builds).
module tb_data_memory_responder;

    localparam int WAITC = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, mem_read, mem_write;
    logic [31:0] address, write_data, read_data;
    logic        resp_valid, resp_ready, addr_error;

    logic        z_req_valid, z_req_ready, z_mem_read, z_mem_write;
    logic [31:0] z_address, z_write_data, z_read_data;
    logic        z_resp_valid, z_addr_error;

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] model [DEPTH];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [15];

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .Clk(clk), .Rst(rst), .ReqValid(req_valid), .ReqReady(req_ready),
        .Address(address), .WriteData(write_data), .MemRead(mem_read), .MemWrite(mem_write),
        .RespValid(resp_valid), .RespReady(resp_ready), .ReadData(read_data), .AddrError(addr_error)
    );

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .Clk(clk), .Rst(rst), .ReqValid(z_req_valid), .ReqReady(z_req_ready),
        .Address(z_address), .WriteData(z_write_data), .MemRead(z_mem_read), .MemWrite(z_mem_write),
        .RespValid(z_resp_valid), .RespReady(1'b1), .ReadData(z_read_data), .AddrError(z_addr_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // One full transaction on the WAIT_CYCLES=2 instance; called at posedge+1.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic exp_err, input logic [31:0] exp_data, input string name);
        check({name, " ready_idle"}, req_ready, 1'b1);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; address = a; write_data = d;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = ~rd; mem_write = ~wr; address = ~a; write_data = ~d;
        check({name, " ready_drop"}, req_ready, 1'b0);
        check({name, " rv_early0"}, resp_valid, 1'b0);
        for (int k = 0; k < WAITC; k++) begin
            @(posedge clk); #1;
            check({name, " rv_early"}, resp_valid, 1'b0);
        end
        @(posedge clk); #1;
        check({name, " rv"}, resp_valid, 1'b1);
        check({name, " err"}, addr_error, exp_err);
        check({name, " data"}, read_data, exp_data);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({name, " rv_done"}, resp_valid, 1'b0);
        check({name, " ready_back"}, req_ready, 1'b1);
    endtask

    // One transaction on the WAIT_CYCLES=0 instance with RespReady tied high.
    task automatic ztxn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input string name);
        check({name, " ready_idle"}, z_req_ready, 1'b1);
        z_req_valid = 1'b1; z_mem_read = rd; z_mem_write = wr; z_address = a; z_write_data = d;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        check({name, " ready_drop"}, z_req_ready, 1'b0);
        check({name, " rv_early"}, z_resp_valid, 1'b0);
        @(posedge clk); #1;
        check({name, " rv"}, z_resp_valid, 1'b1);
        check({name, " err"}, z_addr_error, 1'b0);
        check({name, " data"}, z_read_data, exp_data);
        @(posedge clk); #1;
        check({name, " rv_done"}, z_resp_valid, 1'b0);
        check({name, " ready_back"}, z_req_ready, 1'b1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hBAD0_BAD0, 1'b1, 32'h0000_0000};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h7777_7777, 1'b1, 32'h0000_0000};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0008, 32'h6666_6666, 1'b1, 32'h0000_0000};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'hC0DE_0002};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 32'hC0DE_00FF};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0F0F_0F0F, 1'b0, 32'h0000_0000};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 32'h0F0F_0F0F};
        vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[12] = '{1'b0, 1'b1, 32'h0000_0022, 32'h1111_1111, 1'b1, 32'h0000_0000};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'hC0DE_0008};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hC0DE_0000};

        rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        address = 32'd0; write_data = 32'd0; resp_ready = 1'b0;
        z_req_valid = 1'b0; z_mem_read = 1'b0; z_mem_write = 1'b0;
        z_address = 32'd0; z_write_data = 32'd0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("reset ReqReady", req_ready, 1'b1);
        check("reset RespValid", resp_valid, 1'b0);
        check("reset ReadData", read_data, 32'd0);
        check("reset AddrError", addr_error, 1'b0);
        check("reset0 ReqReady", z_req_ready, 1'b1);
        check("reset0 RespValid", z_resp_valid, 1'b0);
        rst = 1'b0;

        // Fill every word with a known pattern.
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = pat(i);
            txn(1'b0, 1'b1, 32'(i * 4), pat(i), 1'b0, 32'd0, $sformatf("init%0d", i));
        end

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rdata,
                $sformatf("vec%0d", i));
            if (vecs[i].wr && !vecs[i].rd && !vecs[i].err) begin
                model[vecs[i].addr[9:2]] = vecs[i].wdata;
            end
        end

        // Scan all words: error stores must not have written anything.
        for (int i = 0; i < DEPTH; i++) begin
            txn(1'b1, 1'b0, 32'(i * 4), 32'd0, 1'b0, model[i], $sformatf("scan%0d", i));
        end

        // Backpressure: response held for 5 cycles while a new request waits.
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; address = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (WAITC + 1) @(posedge clk);
        #1;
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; address = 32'h3FC;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d rv", k), resp_valid, 1'b1);
            check($sformatf("bp%0d data", k), read_data, 32'hDEAD_BEEF);
            check($sformatf("bp%0d err", k), addr_error, 1'b0);
            check($sformatf("bp%0d ready", k), req_ready, 1'b0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp release rv", resp_valid, 1'b0);
        check("bp release ready", req_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp no_extra%0d", k), resp_valid, 1'b0);
        end

        // Reset while a store is waiting: no write, outputs back to reset values.
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; address = 32'h20; write_data = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstwait ReqReady", req_ready, 1'b1);
        check("rstwait RespValid", resp_valid, 1'b0);
        check("rstwait ReadData", read_data, 32'd0);
        check("rstwait AddrError", addr_error, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("rstwait still_idle", resp_valid, 1'b0);
        txn(1'b1, 1'b0, 32'h20, 32'd0, 1'b0, model[8], "rstwait readback");

        // Reset while a store sits in RESP: write already committed, response dropped.
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; address = 32'h24; write_data = 32'h55AA_55AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (WAITC + 1) @(posedge clk);
        #1;
        check("rstresp rv", resp_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstresp rv_drop", resp_valid, 1'b0);
        check("rstresp ready", req_ready, 1'b1);
        model[9] = 32'h55AA_55AA;
        txn(1'b1, 1'b0, 32'h24, 32'd0, 1'b0, model[9], "rstresp readback");

        // Zero-wait build: stores then 4 back-to-back loads.
        for (int i = 0; i < 4; i++) begin
            ztxn(1'b0, 1'b1, 32'h40 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 32'd0, $sformatf("z_st%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            ztxn(1'b1, 1'b0, 32'h40 + 32'(i * 4), 32'd0, 32'hA5A5_0000 + 32'(i), $sformatf("z_ld%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
